// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pkg
// Brief    : ExcCodes, Status bit positions and arbiter FSM states shared
//            with CP0.
// Revision : 1.0
// ============================================================================
package exc_pkg;

  localparam logic [4:0] c_exc_int = 5'd0;
  localparam logic [4:0] c_exc_sys = 5'd8;
  localparam logic [4:0] c_exc_bp  = 5'd9;
  localparam logic [4:0] c_exc_tr  = 5'd13;

  localparam int c_st_ie    = 0;
  localparam int c_st_exl   = 1;
  localparam int c_st_im_lo = 10;
  localparam int c_st_im_hi = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } exc_state_t;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_adjust(input logic [31:0] pc, input logic dslot);
    return dslot ? (pc - 32'd4) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_sync.sv
`default_nettype none
// ============================================================================
// Module   : int_sync
// Brief    : Per-bit flop chain; STAGES=1 is a plain register stage.
// Revision : 1.0
// ============================================================================
module int_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/exc_arb.sv
`default_nettype none
// ============================================================================
// Module   : exc_arb
// Brief    : Picks one exception/interrupt per boundary, pulses it to CP0,
//            flushes and drains. EXC_ARB_INT_SYNC_EN selects a 2-flop
//            interrupt synchronizer instead of a single register stage.
// Revision : 1.0
// ============================================================================
module exc_arb
  import exc_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  int_raw,
  input  logic        timer_int,
  input  logic [31:0] status,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_dslot,
  input  logic        id_syscall,
  input  logic        id_break,
  input  logic        id_trap,
  input  logic        id_eret,
  input  logic        stall_i,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] epc,
  output logic        delay,
  output logic [5:0]  int_o,
  output logic        flush_o,
  output logic        busy_o
);

`ifdef EXC_ARB_INT_SYNC_EN
  localparam int c_sync_stages = 2;
`else
  localparam int c_sync_stages = 1;
`endif
  localparam logic [3:0] c_drain_init = 4'(DRAIN_CYCLES - 1);

  logic [5:0]  w_int_sync;
  logic        r_timer;
  logic        w_int_ok;
  logic [31:0] r_last_pc;
  logic        r_last_dslot;
  logic [31:0] w_src_pc;
  logic        w_src_dslot;
  logic        w_evt;
  logic        w_eret;
  logic [4:0]  w_cause;
  logic [31:0] w_epc;
  logic        w_delay;
  exc_state_t  r_state;
  logic [3:0]  r_cnt;
  logic        w_status_unused;

  assign w_status_unused = ^{status[31:16], status[9:2]};

  int_sync #(
    .WIDTH  (6),
    .STAGES (c_sync_stages)
  ) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_raw),
    .q     (w_int_sync)
  );

  // Timer is already clk-synchronous, so it only gets one register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) r_timer <= 1'b0;
    else        r_timer <= timer_int;
  end

  assign int_o    = {w_int_sync[5] | r_timer, w_int_sync[4:0]};
  assign w_int_ok = (|(int_o & status[c_st_im_hi:c_st_im_lo])) &
                    status[c_st_ie] & ~status[c_st_exl];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_pc    <= '0;
      r_last_dslot <= 1'b0;
    end else if (id_valid) begin
      r_last_pc    <= id_pc;
      r_last_dslot <= id_dslot;
    end
  end

  assign w_src_pc    = id_valid ? id_pc    : r_last_pc;
  assign w_src_dslot = id_valid ? id_dslot : r_last_dslot;

  always_comb begin
    w_evt   = 1'b0;
    w_eret  = 1'b0;
    w_cause = c_exc_int;
    w_epc   = epc_adjust(id_pc, id_dslot);
    w_delay = id_dslot;
    if (id_valid && id_eret) begin
      w_evt   = 1'b1;
      w_eret  = 1'b1;
      w_epc   = id_pc;
      w_delay = 1'b0;
    end else if (id_valid && id_syscall) begin
      w_evt   = 1'b1;
      w_cause = c_exc_sys;
    end else if (id_valid && id_break) begin
      w_evt   = 1'b1;
      w_cause = c_exc_bp;
    end else if (id_valid && id_trap) begin
      w_evt   = 1'b1;
      w_cause = c_exc_tr;
    end else if (w_int_ok) begin
      w_evt   = 1'b1;
      w_epc   = epc_adjust(w_src_pc, w_src_dslot);
      w_delay = w_src_dslot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      exception <= 1'b0;
      eret      <= 1'b0;
      cause     <= '0;
      epc       <= '0;
      delay     <= 1'b0;
      flush_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stall_i && w_evt) begin
            r_state   <= ST_ISSUE;
            exception <= 1'b1;
            flush_o   <= 1'b1;
            busy_o    <= 1'b1;
            eret      <= w_eret;
            cause     <= w_cause;
            epc       <= w_epc;
            delay     <= w_delay;
          end
        end
        ST_ISSUE: begin
          r_state   <= ST_DRAIN;
          exception <= 1'b0;
          flush_o   <= 1'b0;
          eret      <= 1'b0;
          r_cnt     <= c_drain_init;
        end
        ST_DRAIN: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_arb
// Brief    : Directed vector table plus hand sequences for exc_arb.
// Revision : 1.0
// ============================================================================
module tb_exc_arb;

  localparam int D = 2;
`ifdef EXC_ARB_INT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  int_raw;
  logic        timer_int;
  logic [31:0] status;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_dslot, id_syscall, id_break, id_trap, id_eret, stall_i;
  logic        exception, eret, delay, flush_o, busy_o;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [5:0]  int_o;

  int total = 0;
  int bad   = 0;

  exc_arb #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .int_raw(int_raw), .timer_int(timer_int),
    .status(status), .id_valid(id_valid), .id_pc(id_pc), .id_dslot(id_dslot),
    .id_syscall(id_syscall), .id_break(id_break), .id_trap(id_trap),
    .id_eret(id_eret), .stall_i(stall_i), .exception(exception), .eret(eret),
    .cause(cause), .epc(epc), .delay(delay), .int_o(int_o),
    .flush_o(flush_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        dslot, sys, brk, trap, er;
    logic        x_exc, x_eret;
    logic [4:0]  x_cause;
    logic [31:0] x_epc;
    logic        x_delay;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id;
    id_valid = 0; id_dslot = 0; id_syscall = 0; id_break = 0;
    id_trap = 0; id_eret = 0; id_pc = 32'hDEADBEEF;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && busy_o; i++) tick;
    chk("wait_idle", busy_o, 0);
  endtask

  // Called right after the pulse sample: D drain cycles busy, then idle.
  task automatic check_drain(input string name);
    for (int k = 1; k <= D; k++) begin
      tick;
      chk({name, "_drain_busy"}, busy_o, 1);
      chk({name, "_drain_exc"}, exception, 0);
      chk({name, "_drain_flush"}, flush_o, 0);
      chk({name, "_drain_eret"}, eret, 0);
    end
    tick;
    chk({name, "_idle_busy"}, busy_o, 0);
    chk({name, "_idle_exc"}, exception, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          valid pc            ds sy bk tr er  exc eret cause  epc            dly
    vecs[0] = '{1'b1, 32'h00400100, 1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 5'd8,  32'h00400100, 1'b0};
    vecs[1] = '{1'b1, 32'h00400204, 1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0, 5'd9,  32'h00400200, 1'b1};
    vecs[2] = '{1'b1, 32'h00400010, 1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0, 5'd13, 32'h00400010, 1'b0};
    vecs[3] = '{1'b1, 32'h00400404, 1'b1,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1, 5'd0,  32'h00400404, 1'b0};
    vecs[4] = '{1'b1, 32'h00400500, 1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0, 5'd8,  32'h00400500, 1'b0};
    vecs[5] = '{1'b1, 32'h00000000, 1'b1,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0, 5'd9,  32'hFFFFFFFC, 1'b1};
    vecs[6] = '{1'b0, 32'h00400600, 1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0, 5'd0,  32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 32'h00400700, 1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0, 5'd13, 32'h004006FC, 1'b1};

    rst_n = 0; int_raw = 0; timer_int = 0; status = 0; stall_i = 0;
    clear_id;
    tick; tick;
    chk("rst_exc", exception, 0);
    chk("rst_eret", eret, 0);
    chk("rst_cause", cause, 0);
    chk("rst_epc", epc, 0);
    chk("rst_delay", delay, 0);
    chk("rst_int_o", int_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_n = 1;
    tick;
    chk("post_rst_exc", exception, 0);

    // Table: requests stay asserted through DRAIN, which must ignore them.
    foreach (vecs[i]) begin
      wait_idle;
      id_valid = vecs[i].valid; id_pc = vecs[i].pc; id_dslot = vecs[i].dslot;
      id_syscall = vecs[i].sys; id_break = vecs[i].brk;
      id_trap = vecs[i].trap; id_eret = vecs[i].er;
      tick;
      chk($sformatf("v%0d_exc", i), exception, vecs[i].x_exc);
      chk($sformatf("v%0d_flush", i), flush_o, vecs[i].x_exc);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].x_exc);
      if (vecs[i].x_exc) begin
        chk($sformatf("v%0d_eret", i), eret, vecs[i].x_eret);
        chk($sformatf("v%0d_cause", i), cause, vecs[i].x_cause);
        chk($sformatf("v%0d_epc", i), epc, vecs[i].x_epc);
        chk($sformatf("v%0d_delay", i), delay, vecs[i].x_delay);
        check_drain($sformatf("v%0d", i));
      end
      clear_id;
    end

    // Priority: eret beats trap and a pending eligible interrupt.
    wait_idle;
    status = 32'h0000FC01; int_raw = 6'b000001; stall_i = 1;
    for (int k = 0; k <= SYNC; k++) begin
      tick;
      chk("prio_stalled_exc", exception, 0);
    end
    chk("prio_int_o", int_o, 6'b000001);
    id_valid = 1; id_eret = 1; id_trap = 1; id_pc = 32'h00400800; id_dslot = 0;
    stall_i = 0;
    tick;
    chk("prio_exc", exception, 1);
    chk("prio_eret", eret, 1);
    chk("prio_cause", cause, 0);
    chk("prio_epc", epc, 32'h00400800);
    status = 32'h0000FC03;
    check_drain("prio");
    clear_id; int_raw = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("prio_after_exc", exception, 0);
    end
    status = 0;

    // External interrupt, no valid decode: EPC comes from last valid PC.
    wait_idle;
    status = 32'h0000FC01; int_raw = 6'b000100;
    for (int k = 1; k <= SYNC; k++) begin
      tick;
      chk($sformatf("int_o2_edge%0d", k), int_o[2], (k == SYNC));
      chk($sformatf("int_exc_edge%0d", k), exception, 0);
    end
    tick;
    chk("int_exc", exception, 1);
    chk("int_cause", cause, 0);
    chk("int_eret", eret, 0);
    chk("int_epc", epc, 32'h00400800);
    chk("int_delay", delay, 0);
    status = 32'h0000FC03;
    check_drain("int");
    for (int k = 0; k < 6; k++) begin
      tick;
      chk("int_exl_masked", exception, 0);
    end
    int_raw = 0; status = 0;
    repeat (3) tick;

    // Timer interrupt via bit 5, one register stage.
    wait_idle;
    status = 32'h00008001; id_valid = 1; id_pc = 32'h00400900; id_dslot = 0;
    timer_int = 1;
    tick;
    chk("tmr_int_o", int_o, 6'b100000);
    chk("tmr_exc_early", exception, 0);
    tick;
    chk("tmr_exc", exception, 1);
    chk("tmr_cause", cause, 0);
    chk("tmr_epc", epc, 32'h00400900);
    status = 32'h00008003; timer_int = 0;
    check_drain("tmr");
    clear_id; status = 0;

    // Stall holds off a syscall; then back-to-back reissue; then reset in DRAIN.
    wait_idle;
    id_valid = 1; id_syscall = 1; id_pc = 32'h00400A00; stall_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stall_exc", exception, 0);
      chk("stall_busy", busy_o, 0);
    end
    stall_i = 0;
    tick;
    chk("stall_rel_exc", exception, 1);
    chk("stall_rel_cause", cause, 8);
    chk("stall_rel_epc", epc, 32'h00400A00);
    check_drain("stall");
    tick;
    chk("b2b_exc", exception, 1);
    chk("b2b_cause", cause, 8);
    clear_id;
    tick;
    chk("pre_rst_busy", busy_o, 1);
    rst_n = 0;
    tick;
    chk("mid_rst_exc", exception, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_cause", cause, 0);
    chk("mid_rst_epc", epc, 0);
    chk("mid_rst_flush", flush_o, 0);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("post_mid_rst_exc", exception, 0);
      chk("post_mid_rst_busy", busy_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
